// File: rtl/riscv_gpr_pkg.sv
// Shared constants and types for the GPR write path.
// Used by all builds, with or without RISCV_GPR_WRITE_BYPASS_EN.
package riscv_gpr_pkg;

   localparam int GPR_ADDR_W = 5;
   localparam int GPR_COUNT  = 32;
   localparam int GPR_XLEN   = 32;

   typedef struct packed {
      logic [GPR_ADDR_W-1:0] addr;
      logic [GPR_XLEN-1:0]   data;
   } gpr_wr_entry_t;

   function automatic logic [GPR_COUNT-1:0] gpr_onehot(input logic [GPR_ADDR_W-1:0] addr);
      gpr_onehot       = '0;
      gpr_onehot[addr] = 1'b1;
   endfunction

endpackage

// File: rtl/riscv_gpr_writer_if.sv
// Write-back request and operand-read bundle between the pipeline and the GPR writer.
// The pipeline drives the master modport and the GPR writer uses the slave modport.
interface riscv_gpr_writer_if
   import riscv_gpr_pkg::*;
#(
   parameter int XLEN = 32
);

   logic                  wr_valid;
   logic                  wr_ready;
   logic [GPR_ADDR_W-1:0] wr_addr;
   logic [XLEN-1:0]       wr_data;
   logic                  drain_hold;
   logic [GPR_ADDR_W-1:0] reg_read_addr_1;
   logic [XLEN-1:0]       reg_read_data_1;
   logic [GPR_ADDR_W-1:0] reg_read_addr_2;
   logic [XLEN-1:0]       reg_read_data_2;
   logic [GPR_COUNT-1:0]  pending_mask;
   logic                  queue_empty;

   modport master (
      output wr_valid, wr_addr, wr_data, drain_hold, reg_read_addr_1, reg_read_addr_2,
      input  wr_ready, reg_read_data_1, reg_read_data_2, pending_mask, queue_empty
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, drain_hold, reg_read_addr_1, reg_read_addr_2,
      output wr_ready, reg_read_data_1, reg_read_data_2, pending_mask, queue_empty
   );

endinterface

// File: rtl/riscv_gpr_wq.sv
// In-order write queue holding pending GPR writes, with the pending-register mask.
// With RISCV_GPR_WRITE_BYPASS_EN defined, it also provides youngest-match lookups for the two read ports.
module riscv_gpr_wq
   import riscv_gpr_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [GPR_ADDR_W-1:0] push_addr,
   input  logic [XLEN-1:0]       push_data,
   input  logic                  pop,
   output logic [GPR_ADDR_W-1:0] head_addr,
   output logic [XLEN-1:0]       head_data,
   output logic                  full,
   output logic                  empty,
   output logic [GPR_COUNT-1:0]  pending_mask
`ifdef RISCV_GPR_WRITE_BYPASS_EN
   ,
   input  logic [GPR_ADDR_W-1:0] lookup_addr_1,
   output logic                  lookup_hit_1,
   output logic [XLEN-1:0]       lookup_data_1,
   input  logic [GPR_ADDR_W-1:0] lookup_addr_2,
   output logic                  lookup_hit_2,
   output logic [XLEN-1:0]       lookup_data_2
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [GPR_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
   } entry_t;

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] head_ptr;
   logic [PTR_W-1:0] tail_ptr;
   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[tail_ptr] <= '{addr: push_addr, data: push_data};
            tail_ptr      <= tail_ptr + 1'b1;
         end
         if (pop) begin
            head_ptr <= head_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (!push && pop) begin
            count <= count - 1'b1;
         end
      end
   end

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign head_addr = mem[head_ptr].addr;
   assign head_data = mem[head_ptr].data;

   // Walk entries by age from the head; only the first `count` ages are occupied.
   always_comb begin
      pending_mask = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (CNT_W'(k) < count) begin
            pending_mask = pending_mask | gpr_onehot(mem[head_ptr + PTR_W'(k)].addr);
         end
      end
      pending_mask[0] = 1'b0;
   end

`ifdef RISCV_GPR_WRITE_BYPASS_EN
   // Later (younger) matches overwrite earlier ones, so the youngest match wins.
   always_comb begin
      lookup_hit_1  = 1'b0;
      lookup_data_1 = '0;
      lookup_hit_2  = 1'b0;
      lookup_data_2 = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (CNT_W'(k) < count) begin
            if (mem[head_ptr + PTR_W'(k)].addr == lookup_addr_1) begin
               lookup_hit_1  = 1'b1;
               lookup_data_1 = mem[head_ptr + PTR_W'(k)].data;
            end
            if (mem[head_ptr + PTR_W'(k)].addr == lookup_addr_2) begin
               lookup_hit_2  = 1'b1;
               lookup_data_2 = mem[head_ptr + PTR_W'(k)].data;
            end
         end
      end
   end
`endif

endmodule

// File: rtl/riscv_gpr_writer.sv
// GPR write side: queued write-back into a flop array, with two combinational read ports.
// RISCV_GPR_WRITE_BYPASS_EN lets reads see pending queued writes; otherwise reads show only the array.
module riscv_gpr_writer
   import riscv_gpr_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   riscv_gpr_writer_if.slave        bus
);

   logic                  push;
   logic                  pop;
   logic                  full;
   logic                  empty;
   logic [GPR_ADDR_W-1:0] head_addr;
   logic [XLEN-1:0]       head_data;
   logic [XLEN-1:0]       regs [GPR_COUNT];

`ifdef RISCV_GPR_WRITE_BYPASS_EN
   logic                  hit_1;
   logic                  hit_2;
   logic [XLEN-1:0]       byp_data_1;
   logic [XLEN-1:0]       byp_data_2;
`endif

   // x0 writes complete the handshake but are dropped here, so x0 never reaches the array.
   assign push            = bus.wr_valid & ~full & (bus.wr_addr != '0);
   assign pop             = ~empty & ~bus.drain_hold;
   assign bus.wr_ready    = ~full;
   assign bus.queue_empty = empty;

   riscv_gpr_wq #(
      .DEPTH (DEPTH),
      .XLEN  (XLEN)
   ) u_wq (
      .clk           (clk),
      .rst_n         (rst_n),
      .push          (push),
      .push_addr     (bus.wr_addr),
      .push_data     (bus.wr_data),
      .pop           (pop),
      .head_addr     (head_addr),
      .head_data     (head_data),
      .full          (full),
      .empty         (empty),
      .pending_mask  (bus.pending_mask)
`ifdef RISCV_GPR_WRITE_BYPASS_EN
      ,
      .lookup_addr_1 (bus.reg_read_addr_1),
      .lookup_hit_1  (hit_1),
      .lookup_data_1 (byp_data_1),
      .lookup_addr_2 (bus.reg_read_addr_2),
      .lookup_hit_2  (hit_2),
      .lookup_data_2 (byp_data_2)
`endif
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < GPR_COUNT; i++) begin
            regs[i] <= '0;
         end
      end else if (pop) begin
         regs[head_addr] <= head_data;
      end
   end

   always_comb begin
      bus.reg_read_data_1 = '0;
      bus.reg_read_data_2 = '0;
      if (bus.reg_read_addr_1 != '0) begin
         bus.reg_read_data_1 = regs[bus.reg_read_addr_1];
`ifdef RISCV_GPR_WRITE_BYPASS_EN
         if (hit_1) begin
            bus.reg_read_data_1 = byp_data_1;
         end
`endif
      end
      if (bus.reg_read_addr_2 != '0) begin
         bus.reg_read_data_2 = regs[bus.reg_read_addr_2];
`ifdef RISCV_GPR_WRITE_BYPASS_EN
         if (hit_2) begin
            bus.reg_read_data_2 = byp_data_2;
         end
`endif
      end
   end

endmodule

// File: tb/tb_riscv_gpr_writer.sv
// Bench for riscv_gpr_writer: directed scenarios plus random traffic against a queue-based model.
// Expected read data follows RISCV_GPR_WRITE_BYPASS_EN, the same macro that configures the DUT.
module tb_riscv_gpr_writer;

   localparam int DEPTH = 2;
   localparam int XLEN  = 32;

`ifdef RISCV_GPR_WRITE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   riscv_gpr_writer_if #(.XLEN(XLEN)) bus ();

   riscv_gpr_writer #(
      .DEPTH (DEPTH),
      .XLEN  (XLEN)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } m_entry_t;

   m_entry_t    m_q [$];
   logic [31:0] m_regs [32];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [31:0] expRead(input logic [4:0] addr);
      if (addr == 5'd0) return 32'h0;
      if (BYPASS) begin
         for (int i = m_q.size() - 1; i >= 0; i--) begin
            if (m_q[i].addr == addr) return m_q[i].data;
         end
      end
      return m_regs[addr];
   endfunction

   function automatic logic [31:0] expPending();
      logic [31:0] m;
      m = '0;
      foreach (m_q[i]) m[m_q[i].addr] = 1'b1;
      return m;
   endfunction

   // Reference model: a plain FIFO plus an array, updated at each edge.
   initial begin
      foreach (m_regs[i]) m_regs[i] = '0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_q.delete();
            foreach (m_regs[i]) m_regs[i] = '0;
         end else begin
            bit       can_push;
            m_entry_t e;
            can_push = (m_q.size() != DEPTH);
            if (m_q.size() > 0 && !bus.drain_hold) begin
               m_regs[m_q[0].addr] = m_q[0].data;
               void'(m_q.pop_front());
            end
            if (bus.wr_valid && can_push && bus.wr_addr != 5'd0) begin
               e.addr = bus.wr_addr;
               e.data = bus.wr_data;
               m_q.push_back(e);
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         checkOutput("wr_ready", 32'(bus.wr_ready), 32'(m_q.size() != DEPTH));
         checkOutput("queue_empty", 32'(bus.queue_empty), 32'(m_q.size() == 0));
         checkOutput("pending_mask", bus.pending_mask, expPending());
         checkOutput("rd1", bus.reg_read_data_1, expRead(bus.reg_read_addr_1));
         checkOutput("rd2", bus.reg_read_data_2, expRead(bus.reg_read_addr_2));
      end
   end

   task automatic applyStimulus(input logic v, input logic [4:0] a, input logic [31:0] d,
                                input logic h, input logic [4:0] r1, input logic [4:0] r2);
      bus.wr_valid        = v;
      bus.wr_addr         = a;
      bus.wr_data         = d;
      bus.drain_hold      = h;
      bus.reg_read_addr_1 = r1;
      bus.reg_read_addr_2 = r2;
      @(posedge clk);
      #2;
   endtask

   initial begin
      bus.wr_valid        = 1'b0;
      bus.wr_addr         = '0;
      bus.wr_data         = '0;
      bus.drain_hold      = 1'b0;
      bus.reg_read_addr_1 = 5'd5;
      bus.reg_read_addr_2 = 5'd0;
      #3;
      checkOutput("reset_wr_ready", 32'(bus.wr_ready), 32'd1);
      checkOutput("reset_empty", 32'(bus.queue_empty), 32'd1);
      checkOutput("reset_pending", bus.pending_mask, 32'h0);
      checkOutput("reset_rd1", bus.reg_read_data_1, 32'h0);
      #9 rst_n = 1'b1;

      applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0);
      checkOutput("basic_pend5_set", 32'(bus.pending_mask[5]), 32'd1);
      checkOutput("basic_rd1_early", bus.reg_read_data_1, BYPASS ? 32'hDEADBEEF : 32'h0);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0);
      checkOutput("basic_rd1", bus.reg_read_data_1, 32'hDEADBEEF);
      checkOutput("basic_pend5_clr", 32'(bus.pending_mask[5]), 32'd0);

      applyStimulus(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0);
      checkOutput("x0_empty", 32'(bus.queue_empty), 32'd1);
      checkOutput("x0_read", bus.reg_read_data_1, 32'h0);

      applyStimulus(1'b1, 5'd1, 32'd1, 1'b1, 5'd1, 5'd2);
      checkOutput("hold_ready_1", 32'(bus.wr_ready), 32'd1);
      applyStimulus(1'b1, 5'd2, 32'd2, 1'b1, 5'd1, 5'd2);
      checkOutput("hold_full_ready", 32'(bus.wr_ready), 32'd0);
      checkOutput("hold_full_pend", bus.pending_mask, 32'h6);
      applyStimulus(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd2);
      checkOutput("hold_third_pend", bus.pending_mask, 32'h6);
      checkOutput("hold_third_rd", bus.reg_read_data_1, 32'h0);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd2);
      checkOutput("release_x1", bus.reg_read_data_1, 32'd1);
      checkOutput("release_x2_early", bus.reg_read_data_2, BYPASS ? 32'd2 : 32'd0);
      checkOutput("release_ready", 32'(bus.wr_ready), 32'd1);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd2);
      checkOutput("release_x2", bus.reg_read_data_2, 32'd2);
      checkOutput("release_empty", 32'(bus.queue_empty), 32'd1);

      applyStimulus(1'b1, 5'd7, 32'hA, 1'b0, 5'd7, 5'd0);
      checkOutput("order_x7_a", bus.reg_read_data_1, BYPASS ? 32'hA : 32'h0);
      applyStimulus(1'b1, 5'd7, 32'hB, 1'b0, 5'd7, 5'd0);
      checkOutput("order_x7_b", bus.reg_read_data_1, BYPASS ? 32'hB : 32'hA);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0);
      checkOutput("order_x7_final", bus.reg_read_data_1, 32'hB);

      applyStimulus(1'b1, 5'd3, 32'h55, 1'b1, 5'd3, 5'd0);
      checkOutput("held_pend3", 32'(bus.pending_mask[3]), 32'd1);
      checkOutput("held_rd_x3", bus.reg_read_data_1, BYPASS ? 32'h55 : 32'h0);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0);
      checkOutput("held_rd_x3_still", bus.reg_read_data_1, BYPASS ? 32'h55 : 32'h0);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd0);
      checkOutput("drained_x3", bus.reg_read_data_1, 32'h55);
      checkOutput("drained_pend", bus.pending_mask, 32'h0);

      for (int n = 0; n < 400; n++) begin
         logic       v;
         logic       h;
         logic [4:0] a;
         v = ($urandom_range(0, 9) < 7);
         a = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) a = 5'($urandom_range(0, 31));
         h = ($urandom_range(0, 3) == 0) || (n >= 200 && n < 220);
         applyStimulus(v, a, $urandom, h, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end

      applyStimulus(1'b1, 5'd12, 32'hC0FFEE, 1'b1, 5'd5, 5'd7);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_ready", 32'(bus.wr_ready), 32'd1);
      checkOutput("midrst_empty", 32'(bus.queue_empty), 32'd1);
      checkOutput("midrst_pending", bus.pending_mask, 32'h0);
      checkOutput("midrst_rd1", bus.reg_read_data_1, 32'h0);
      checkOutput("midrst_rd2", bus.reg_read_data_2, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
